backplane_sampler: RTL and testbench
====================================

BACKPLANE_SAMPLER -- requirements
Module: backplane_sampler

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all ports, parameters and outputs are listed in REQ-002 to REQ-018.
REQ-002 Parameter WORD_W, default 8: bits per assembled word, legal range 2..32.
REQ-003 Parameter EDGE_FILT, default 3: length of the edge-history register, legal range 2..6.
REQ-004 Parameter GAP_CYCLES, default 5: number of stable ext_clock cycles that forces bit-counter resynchronisation.
REQ-005 Parameter IDLE_CYCLES, default 255: number of stable ext_clock cycles that declares the bus clock dead; must exceed GAP_CYCLES.
REQ-006 Parameter FIFO_DEPTH, default 4: output FIFO depth, a power of two, 2..16.
REQ-007 clk  in  1  system clock; all logic is on the rising edge.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 ext_clock  in  1  asynchronous backplane clock.
REQ-010 ext_data  in  1  asynchronous backplane data.
REQ-011 invert_data  in  1  when 1, each sampled bit is inverted (active-low bus).
REQ-012 sample_edge  in  1  selects the qualifying edge: 0 = rising, 1 = falling; static while the bus is active.
REQ-013 out_data  out  WORD_W  word at the FIFO head.
REQ-014 out_valid  out  1  FIFO is non-empty.
REQ-015 out_ready  in  1  consumer accepts the head word; a pop occurs when out_valid and out_ready are both 1.
REQ-016 overflow  out  1  sticky flag: at least one completed word was dropped.
REQ-017 overflow_clr  in  1  single-cycle clear of overflow.
REQ-018 clk_deactivate  out  1  bus clock idle.
REQ-018a resync  out  1  one-cycle pulse when a partial word is discarded.

Function
REQ-019 ext_clock and ext_data SHALL each pass through a 2-flop synchroniser; all later logic uses only the synchronised copies.
REQ-020 Each cycle, the synchronised clock SHALL shift into hist[EDGE_FILT-1:0], with the newest sample in the LSB.
REQ-021 A qualified edge SHALL be a hist value whose MSB equals the inactive level and whose remaining bits all equal the active level (rising, EDGE_FILT=3: 3'b011; falling: 3'b100); only one edge is detected per transition.
REQ-022 On a qualified edge, the sampled bit (synchronised ext_data XOR invert_data) SHALL shift into the LSB of the shift register, MSB-first, and bit_cnt SHALL increment.
REQ-023 When bit_cnt equals WORD_W-1 at a qualified edge, the completed word SHALL be pushed to the FIFO in that same cycle, bit_cnt SHALL wrap to 0, and out_valid SHALL rise in the next cycle if the FIFO was empty.
REQ-024 stable_cnt SHALL count cycles since the last change of the synchronised clock, SHALL saturate at IDLE_CYCLES, and SHALL clear on any change.
REQ-025 When stable_cnt reaches GAP_CYCLES: bit_cnt and the shift register SHALL clear; if bit_cnt was nonzero, resync SHALL pulse for one cycle; FIFO contents are unaffected.
REQ-026 clk_deactivate SHALL equal (stable_cnt == IDLE_CYCLES), registered.
REQ-027 While clk_deactivate is 1: no bit is sampled, hist SHALL hold the inactive level, and the FIFO SHALL remain poppable.
REQ-028 A push to a full FIFO without a simultaneous pop SHALL drop the word, keep the FIFO unchanged, and set overflow.
REQ-029 A push and a pop in the same cycle SHALL both succeed at any occupancy, including full and empty.
REQ-030 When an overflow set and overflow_clr occur in the same cycle, overflow SHALL remain set.
REQ-031 out_data SHALL be stable while out_valid=1 and out_ready=0.

Reset
REQ-032 Reset SHALL drive hist to the inactive level, bit_cnt, shift register, FIFO pointers, out_valid, overflow and resync to 0, and out_data to 0.
REQ-033 Reset SHALL set stable_cnt to IDLE_CYCLES, so clk_deactivate=1 until the first clock transition.
REQ-034 A reset during a word SHALL discard the partial word and all queued words, with no resync pulse.

Structure
REQ-035 Default parameter values and the edge-pattern constants SHALL live in the shared package backplane_pkg.
REQ-036 The FIFO SHALL be a separate sub-module, sample_fifo (first-word fall-through, registered full/empty); edge, counter and idle logic stay in backplane_sampler.

Verification
REQ-037 Rising edge, invert=1, WORD_W=8: drive ext_data low for 8 bits (inverts to 1s), with out_ready held 0 -> out_data=8'hFF, out_valid=1 and held stable.
REQ-038 Falling edge, invert=0: send 0xA5 MSB-first -> one word 8'hA5, no resync.
REQ-039 Three bits, then ext_clock held 5 cycles, then 8 bits of 0x3C -> resync pulses once; the only output is 8'h3C.
REQ-040 FIFO_DEPTH=4, out_ready=0: send 5 words -> first four retained in order; overflow=1; overflow_clr clears it.
REQ-041 Full FIFO with push and pop in the same cycle -> occupancy stays 4; no overflow.
REQ-042 Bus stops for 255 cycles mid-word -> clk_deactivate=1, partial word discarded; queued words still drain; rst mid-word -> all outputs at reset values the next cycle.

Source files
------------

// File: rtl/backplane_pkg.sv
// Shared definitions for the backplane sampler.
// Holds the default parameter values, the edge-pattern constants for the
// default filter length, and a helper that builds the qualifying edge
// pattern for any filter length.
package backplane_pkg;

    localparam int unsigned WORD_W_DEF      = 8;
    localparam int unsigned EDGE_FILT_DEF   = 3;
    localparam int unsigned GAP_CYCLES_DEF  = 5;
    localparam int unsigned IDLE_CYCLES_DEF = 255;
    localparam int unsigned FIFO_DEPTH_DEF  = 4;
    localparam int unsigned EDGE_FILT_MAX   = 6;

    // Qualifying edge patterns for the default three-sample history.
    localparam logic [2:0] EDGE_PAT_RISE_DEF = 3'b011;
    localparam logic [2:0] EDGE_PAT_FALL_DEF = 3'b100;

    typedef enum logic {
        EDGE_RISING  = 1'b0,
        EDGE_FALLING = 1'b1
    } edge_sel_e;

    // MSB of the history window is the inactive level, all newer samples
    // are the active level; bits above the window are zero.
    function automatic logic [EDGE_FILT_MAX-1:0] edge_pattern(input int filt, input logic falling);
        logic [EDGE_FILT_MAX-1:0] pat;
        pat = '0;
        for (int i = 0; i < int'(EDGE_FILT_MAX); i++) begin
            if (i == filt - 1) begin
                pat[i] = falling;
            end else if (i < filt - 1) begin
                pat[i] = ~falling;
            end else begin
                pat[i] = 1'b0;
            end
        end
        return pat;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// First-word fall-through FIFO for assembled words.
// Ports: clk/rst (sync, active-high); push/push_data write side;
// pop_req request from the consumer (honoured only when valid);
// head_data registered head word (0 when empty); valid registered non-empty;
// drop is high in a cycle where a push hits a full FIFO with no pop.
module sample_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_req,
    output logic [WIDTH-1:0] head_data,
    output logic             valid,
    output logic             drop
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             valid_q, valid_d;
    logic             full_q, full_d;
    logic             pop_s, wr_en_s, drop_s;

    // Next-state for storage, pointers, occupancy and the registered head.
    always_comb begin
        pop_s    = pop_req && valid_q;
        // A full FIFO still accepts a push when the head leaves this cycle.
        wr_en_s  = push && (!full_q || pop_s);
        drop_s   = push && full_q && !pop_s;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en_s) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({wr_en_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        valid_d = (count_d != CW'(0));
        full_d  = (count_d == CW'(DEPTH));
        // Head is looked up from next-state storage so a word written into
        // an empty FIFO is visible together with valid.
        if (valid_d) begin
            head_d = mem_d[rd_ptr_d];
        end else begin
            head_d = '0;
        end
    end

    // Storage array; contents are only meaningful behind valid pointers.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Pointer, occupancy and head registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            valid_q  <= 1'b0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            valid_q  <= valid_d;
            full_q   <= full_d;
        end
    end

    assign head_data = head_q;
    assign valid     = valid_q;
    assign drop      = drop_s;

endmodule

// File: rtl/backplane_sampler.sv
// Samples a slow asynchronous serial backplane (ext_clock/ext_data) into
// WORD_W-bit words, MSB first, and queues them in a small FWFT FIFO.
// Ports: clk/rst (sync, active-high); ext_clock/ext_data async bus inputs;
// invert_data inverts each sampled bit; sample_edge 0=rising 1=falling;
// out_data/out_valid/out_ready consumer handshake; overflow sticky drop
// flag with overflow_clr; clk_deactivate bus clock idle; resync one-cycle
// pulse when a partial word is discarded after a clock gap.
module backplane_sampler
    import backplane_pkg::*;
#(
    parameter int unsigned WORD_W      = WORD_W_DEF,
    parameter int unsigned EDGE_FILT   = EDGE_FILT_DEF,
    parameter int unsigned GAP_CYCLES  = GAP_CYCLES_DEF,
    parameter int unsigned IDLE_CYCLES = IDLE_CYCLES_DEF,
    parameter int unsigned FIFO_DEPTH  = FIFO_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ext_clock,
    input  logic              ext_data,
    input  logic              invert_data,
    input  logic              sample_edge,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overflow,
    input  logic              overflow_clr,
    output logic              clk_deactivate,
    output logic              resync
);

    localparam int unsigned BC_W = $clog2(WORD_W);
    localparam int unsigned SC_W = $clog2(IDLE_CYCLES + 1);

    logic                 clk_s1_q, clk_s2_q, clk_prev_q;
    logic                 dat_s1_q, dat_s2_q;
    logic [EDGE_FILT-1:0] hist_q, hist_d;
    logic [BC_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [WORD_W-2:0]    shift_q, shift_d;
    logic [SC_W-1:0]      stable_cnt_q, stable_cnt_d;
    logic                 clk_deactivate_q, clk_deactivate_d;
    logic                 resync_q, resync_d;
    logic                 overflow_q, overflow_d;

    logic [EDGE_FILT_MAX-1:0] edge_pat_s;
    logic                     edge_s, gap_s, clk_change_s, bit_s, push_s, drop_s;
    logic [WORD_W-1:0]        push_word_s;

    // Edge qualification, idle/gap tracking, word assembly and overflow.
    always_comb begin
        edge_pat_s   = edge_pattern(int'(EDGE_FILT), sample_edge);
        clk_change_s = clk_s2_q ^ clk_prev_q;
        edge_s       = (EDGE_FILT_MAX'(hist_q) == edge_pat_s) && !clk_deactivate_q;
        gap_s        = (stable_cnt_q == SC_W'(GAP_CYCLES));
        bit_s        = dat_s2_q ^ invert_data;
        push_word_s  = {shift_q, bit_s};

        // A dead bus parks the history at the inactive level so the first
        // real transition after it is seen as a clean edge.
        if (clk_deactivate_q) begin
            hist_d = {EDGE_FILT{sample_edge}};
        end else begin
            hist_d = {hist_q[EDGE_FILT-2:0], clk_s2_q};
        end

        if (clk_change_s) begin
            stable_cnt_d = '0;
        end else if (stable_cnt_q == SC_W'(IDLE_CYCLES)) begin
            stable_cnt_d = stable_cnt_q;
        end else begin
            stable_cnt_d = stable_cnt_q + SC_W'(1);
        end
        clk_deactivate_d = (stable_cnt_d == SC_W'(IDLE_CYCLES));

        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        resync_d  = 1'b0;
        push_s    = 1'b0;
        // The gap check wins over a coincident edge: the word is abandoned.
        if (gap_s) begin
            bit_cnt_d = '0;
            shift_d   = '0;
            resync_d  = (bit_cnt_q != BC_W'(0));
        end else if (edge_s) begin
            shift_d = push_word_s[WORD_W-2:0];
            if (bit_cnt_q == BC_W'(WORD_W - 1)) begin
                bit_cnt_d = '0;
                push_s    = 1'b1;
            end else begin
                bit_cnt_d = bit_cnt_q + BC_W'(1);
            end
        end else begin
            bit_cnt_d = bit_cnt_q;
        end

        // A drop in the same cycle as a clear keeps the flag set.
        if (drop_s) begin
            overflow_d = 1'b1;
        end else if (overflow_clr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Synchronisers, edge history, counters and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1_q         <= sample_edge;
            clk_s2_q         <= sample_edge;
            clk_prev_q       <= sample_edge;
            dat_s1_q         <= 1'b0;
            dat_s2_q         <= 1'b0;
            hist_q           <= {EDGE_FILT{sample_edge}};
            bit_cnt_q        <= '0;
            shift_q          <= '0;
            stable_cnt_q     <= SC_W'(IDLE_CYCLES);
            clk_deactivate_q <= 1'b1;
            resync_q         <= 1'b0;
            overflow_q       <= 1'b0;
        end else begin
            clk_s1_q         <= ext_clock;
            clk_s2_q         <= clk_s1_q;
            clk_prev_q       <= clk_s2_q;
            dat_s1_q         <= ext_data;
            dat_s2_q         <= dat_s1_q;
            hist_q           <= hist_d;
            bit_cnt_q        <= bit_cnt_d;
            shift_q          <= shift_d;
            stable_cnt_q     <= stable_cnt_d;
            clk_deactivate_q <= clk_deactivate_d;
            resync_q         <= resync_d;
            overflow_q       <= overflow_d;
        end
    end

    sample_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data (push_word_s),
        .pop_req   (out_ready),
        .head_data (out_data),
        .valid     (out_valid),
        .drop      (drop_s)
    );

    assign clk_deactivate = clk_deactivate_q;
    assign resync         = resync_q;
    assign overflow       = overflow_q;

endmodule

// File: tb/tb_backplane_sampler.sv
// Directed bench for backplane_sampler with default parameters.
module tb_backplane_sampler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ext_clock = 1'b0;
    logic       ext_data = 1'b0;
    logic       invert_data = 1'b0;
    logic       sample_edge = 1'b0;
    logic       out_ready = 1'b0;
    logic       overflow_clr = 1'b0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       overflow;
    logic       clk_deactivate;
    logic       resync;

    int n_cmp = 0;
    int n_mis = 0;
    int resync_cnt = 0;

    backplane_sampler dut (
        .clk            (clk),
        .rst            (rst),
        .ext_clock      (ext_clock),
        .ext_data       (ext_data),
        .invert_data    (invert_data),
        .sample_edge    (sample_edge),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .overflow       (overflow),
        .overflow_clr   (overflow_clr),
        .clk_deactivate (clk_deactivate),
        .resync         (resync)
    );

    always #5 clk = ~clk;

    // Count cycles in which resync is high.
    always @(posedge clk) begin
        #1;
        if (resync === 1'b1) resync_cnt++;
    end

    // act: 0 nothing, 1 pop at the push cycle, 2 overflow_clr at the push cycle.
    // Push lands on the 5th rising clk edge after the active bus transition.
    task automatic send_bit(input logic b, input int act);
        ext_clock = sample_edge;
        repeat (2) @(negedge clk);
        ext_data = b;
        repeat (2) @(negedge clk);
        ext_clock = ~sample_edge;
        repeat (4) @(negedge clk);
        if (act == 1) begin
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end else if (act == 2) begin
            overflow_clr = 1'b1;
            @(negedge clk);
            overflow_clr = 1'b0;
        end
    endtask

    task automatic send_bits(input logic [7:0] w, input int n);
        for (int i = 7; i > 7 - n; i--) send_bit(w[i], 0);
    endtask

    task automatic send_word(input logic [7:0] w, input int act_last);
        for (int i = 7; i >= 0; i--) send_bit(w[i], (i == 0) ? act_last : 0);
        ext_clock = sample_edge;
        repeat (4) @(negedge clk);
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic do_reset(input logic edge_sel);
        sample_edge  = edge_sel;
        ext_clock    = edge_sel;
        ext_data     = 1'b0;
        out_ready    = 1'b0;
        overflow_clr = 1'b0;
        rst          = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset(1'b0);
        if (out_valid !== 1'b0) begin $display("FAIL reset_valid: got %b want 0", out_valid); n_mis++; end
        n_cmp++;
        if (out_data !== 8'h00) begin $display("FAIL reset_data: got %h want 00", out_data); n_mis++; end
        n_cmp++;
        if (overflow !== 1'b0) begin $display("FAIL reset_ovf: got %b want 0", overflow); n_mis++; end
        n_cmp++;
        if (resync !== 1'b0) begin $display("FAIL reset_resync: got %b want 0", resync); n_mis++; end
        n_cmp++;
        if (clk_deactivate !== 1'b1) begin $display("FAIL reset_deact: got %b want 1", clk_deactivate); n_mis++; end
        n_cmp++;
    endtask

    task automatic test_rise_invert();
        int base;
        base = resync_cnt;
        invert_data = 1'b1;
        send_word(8'h00, 0);
        if (out_valid !== 1'b1) begin $display("FAIL inv_valid: got %b want 1", out_valid); n_mis++; end
        n_cmp++;
        if (out_data !== 8'hFF) begin $display("FAIL inv_data: got %h want ff", out_data); n_mis++; end
        n_cmp++;
        if (clk_deactivate !== 1'b0) begin $display("FAIL inv_deact: got %b want 0", clk_deactivate); n_mis++; end
        n_cmp++;
        repeat (10) @(negedge clk);
        if (out_valid !== 1'b1 || out_data !== 8'hFF) begin
            $display("FAIL inv_hold: got %b/%h want 1/ff", out_valid, out_data); n_mis++;
        end
        n_cmp++;
        if (resync_cnt !== base) begin $display("FAIL inv_resync: got %0d want %0d", resync_cnt, base); n_mis++; end
        n_cmp++;
        pop_one();
        if (out_valid !== 1'b0) begin $display("FAIL inv_pop: got %b want 0", out_valid); n_mis++; end
        n_cmp++;
        invert_data = 1'b0;
    endtask

    task automatic test_fall();
        int base;
        do_reset(1'b1);
        base = resync_cnt;
        send_word(8'hA5, 0);
        if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
            $display("FAIL fall_word: got %b/%h want 1/a5", out_valid, out_data); n_mis++;
        end
        n_cmp++;
        if (resync_cnt !== base) begin $display("FAIL fall_resync: got %0d want %0d", resync_cnt, base); n_mis++; end
        n_cmp++;
        pop_one();
        if (out_valid !== 1'b0) begin $display("FAIL fall_pop: got %b want 0", out_valid); n_mis++; end
        n_cmp++;
    endtask

    task automatic test_resync();
        int base;
        base = resync_cnt;
        send_bits(8'hA0, 3);
        ext_clock = sample_edge;
        repeat (12) @(negedge clk);
        if (resync_cnt !== base + 1) begin $display("FAIL gap_resync: got %0d want %0d", resync_cnt, base + 1); n_mis++; end
        n_cmp++;
        if (out_valid !== 1'b0) begin $display("FAIL gap_nopush: got %b want 0", out_valid); n_mis++; end
        n_cmp++;
        send_word(8'h3C, 0);
        if (out_valid !== 1'b1 || out_data !== 8'h3C) begin
            $display("FAIL gap_word: got %b/%h want 1/3c", out_valid, out_data); n_mis++;
        end
        n_cmp++;
        if (resync_cnt !== base + 1) begin $display("FAIL gap_once: got %0d want %0d", resync_cnt, base + 1); n_mis++; end
        n_cmp++;
        pop_one();
        if (out_valid !== 1'b0) begin $display("FAIL gap_only: got %b want 0", out_valid); n_mis++; end
        n_cmp++;
    endtask

    task automatic test_overflow();
        logic [7:0] exp_q [4];
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) send_word(exp_q[i], 0);
        if (overflow !== 1'b0) begin $display("FAIL ovf_full_noovf: got %b want 0", overflow); n_mis++; end
        n_cmp++;
        // Fifth word is dropped while overflow_clr is pulsed in the same cycle.
        send_word(8'h55, 2);
        if (overflow !== 1'b1) begin $display("FAIL ovf_set_wins: got %b want 1", overflow); n_mis++; end
        n_cmp++;
        overflow_clr = 1'b1;
        @(negedge clk);
        overflow_clr = 1'b0;
        if (overflow !== 1'b0) begin $display("FAIL ovf_clr: got %b want 0", overflow); n_mis++; end
        n_cmp++;
        for (int i = 0; i < 4; i++) begin
            if (out_valid !== 1'b1 || out_data !== exp_q[i]) begin
                $display("FAIL ovf_drain%0d: got %b/%h want 1/%h", i, out_valid, out_data, exp_q[i]); n_mis++;
            end
            n_cmp++;
            pop_one();
        end
        if (out_valid !== 1'b0) begin $display("FAIL ovf_empty: got %b want 0", out_valid); n_mis++; end
        n_cmp++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_q [4];
        for (int i = 0; i < 4; i++) send_word(8'hA1 + 8'(i), 0);
        send_word(8'hB5, 1);
        if (overflow !== 1'b0) begin $display("FAIL b2b_noovf: got %b want 0", overflow); n_mis++; end
        n_cmp++;
        exp_q = '{8'hA2, 8'hA3, 8'hA4, 8'hB5};
        for (int i = 0; i < 4; i++) begin
            if (out_valid !== 1'b1 || out_data !== exp_q[i]) begin
                $display("FAIL b2b_drain%0d: got %b/%h want 1/%h", i, out_valid, out_data, exp_q[i]); n_mis++;
            end
            n_cmp++;
            pop_one();
        end
        if (out_valid !== 1'b0) begin $display("FAIL b2b_empty: got %b want 0", out_valid); n_mis++; end
        n_cmp++;
    endtask

    task automatic test_idle();
        int base;
        send_word(8'h5A, 0);
        base = resync_cnt;
        send_bits(8'hF0, 3);
        ext_clock = sample_edge;
        repeat (300) @(negedge clk);
        if (clk_deactivate !== 1'b1) begin $display("FAIL idle_deact: got %b want 1", clk_deactivate); n_mis++; end
        n_cmp++;
        if (resync_cnt !== base + 1) begin $display("FAIL idle_resync: got %0d want %0d", resync_cnt, base + 1); n_mis++; end
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 8'h5A) begin
            $display("FAIL idle_queued: got %b/%h want 1/5a", out_valid, out_data); n_mis++;
        end
        n_cmp++;
        pop_one();
        if (out_valid !== 1'b0) begin $display("FAIL idle_drain: got %b want 0", out_valid); n_mis++; end
        n_cmp++;
        send_word(8'hC3, 0);
        if (clk_deactivate !== 1'b0) begin $display("FAIL idle_wake: got %b want 0", clk_deactivate); n_mis++; end
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 8'hC3) begin
            $display("FAIL idle_clean: got %b/%h want 1/c3", out_valid, out_data); n_mis++;
        end
        n_cmp++;
        pop_one();
    endtask

    task automatic test_reset_mid_word();
        int base;
        for (int i = 0; i < 5; i++) send_word(8'h70 + 8'(i), 0);
        if (overflow !== 1'b1) begin $display("FAIL rmw_pre_ovf: got %b want 1", overflow); n_mis++; end
        n_cmp++;
        send_bits(8'hE0, 3);
        ext_clock = sample_edge;
        repeat (2) @(negedge clk);
        base = resync_cnt;
        rst = 1'b1;
        @(negedge clk);
        if (out_valid !== 1'b0 || out_data !== 8'h00) begin
            $display("FAIL rmw_fifo: got %b/%h want 0/00", out_valid, out_data); n_mis++;
        end
        n_cmp++;
        if (overflow !== 1'b0 || resync !== 1'b0 || clk_deactivate !== 1'b1) begin
            $display("FAIL rmw_flags: got ovf=%b rs=%b dz=%b want 0/0/1", overflow, resync, clk_deactivate); n_mis++;
        end
        n_cmp++;
        rst = 1'b0;
        repeat (20) @(negedge clk);
        if (resync_cnt !== base) begin $display("FAIL rmw_noresync: got %0d want %0d", resync_cnt, base); n_mis++; end
        n_cmp++;
        if (out_valid !== 1'b0) begin $display("FAIL rmw_empty: got %b want 0", out_valid); n_mis++; end
        n_cmp++;
    endtask

    initial begin
        test_reset();
        test_rise_invert();
        test_fall();
        test_resync();
        test_overflow();
        test_back_to_back();
        test_idle();
        test_reset_mid_word();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
